instr_fetch: RTL

//  Fetch stage directly upstream of instr_mem. Owns the PC and drives the memory address.

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_skid_buf.sv | 44 ++++
 rtl/instr_fetch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the fetch stage and its helpers.
//   - instruction_s  : instruction word as stored in instr_mem (32 bits)
//   - fetch_state_e  : fetch sequencer state (HALT / RUN)
//   - DEFAULT_*      : default address width and PC loaded on start
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  rd;
    logic [15:0] imm;
  } instruction_s;

  typedef enum logic [0:0] {
    HALT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 10;
  localparam int unsigned DEFAULT_RESET_PC   = 0;

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
//   One-entry holding register for an {instruction, pc} pair that arrived from
//   instr_mem while decode was not accepting. Clear wins over load.
// Ports
//   clk, reset_i      clock, synchronous active-high reset (empties the buffer)
//   clear             drop the held entry
//   load              capture capture_instr/capture_pc (ignored if clear)
//   capture_instr/pc  entry to capture
//   full              an entry is held
//   instr, pc         held entry (meaningful only while full)
// -----------------------------------------------------------------------------
module fetch_skid_buf
  import instr_fetch_pkg::*;
#(
  parameter int unsigned addr_width_p = DEFAULT_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic                    clear,
  input  logic                    load,
  input  instruction_s            capture_instr,
  input  logic [addr_width_p-1:0] capture_pc,
  output logic                    full,
  output instruction_s            instr,
  output logic [addr_width_p-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset_i)    full <= 1'b0;
    else if (clear) full <= 1'b0;
    else if (load)  full <= 1'b1;
  end

  // NOTE: the payload carries no reset; it is only observed while full is
  // set, so resetting it would add logic without changing behaviour.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      instr <= capture_instr;
      pc    <= capture_pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage in front of a 1-cycle synchronous-read instr_mem. Owns the PC,
//   drives the memory address, absorbs the read latency and hands
//   {instruction, pc} to decode over valid/ready. While halted, the program
//   load port is routed straight through to the memory write port.
//
// Parameters
//   addr_width_p  PC / memory address width; PC wraps modulo 2**addr_width_p
//   reset_pc_p    PC loaded on start_i
//
// Ports
//   clk, reset_i              clock, synchronous active-high reset
//   start_i / halt_i          HALT->RUN / RUN->HALT (halt_i wins if both)
//   load_we_i/addr_i/instr_i  program write request, honoured in HALT only
//   redirect_i/redirect_pc_i  taken branch/jump and its target
//   ready_i                   decode accepts instr_o this cycle
//   imem_addr_o/wen_o/instr_o to instr_mem
//   imem_instr_i              read data from instr_mem (one cycle after addr)
//   valid_o, instr_o, pc_o    fetched instruction and its address
//
// Optional feature (macro FETCH_PERF_EN)
//   Adds fetch_cnt_o (accepted transfers) and stall_cnt_o (cycles with
//   valid_o && !ready_i). Both saturate and clear on reset_i and on start_i.
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned addr_width_p = DEFAULT_ADDR_WIDTH,
  parameter int unsigned reset_pc_p   = DEFAULT_RESET_PC
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    halt_i,
  input  logic                    load_we_i,
  input  logic [addr_width_p-1:0] load_addr_i,
  input  instruction_s            load_instr_i,
  input  logic                    redirect_i,
  input  logic [addr_width_p-1:0] redirect_pc_i,
  input  logic                    ready_i,
  output logic [addr_width_p-1:0] imem_addr_o,
  output logic                    imem_wen_o,
  output instruction_s            imem_instr_o,
  input  instruction_s            imem_instr_i,
  output logic                    valid_o,
  output instruction_s            instr_o,
  output logic [addr_width_p-1:0] pc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             fetch_cnt_o,
  output logic [31:0]             stall_cnt_o
`endif
);

  localparam logic [addr_width_p-1:0] reset_pc = addr_width_p'(reset_pc_p);
  localparam logic [addr_width_p-1:0] pc_step  = addr_width_p'(1);

  fetch_state_e            state;
  logic [addr_width_p-1:0] pc;
  logic                    inflight_valid;
  logic [addr_width_p-1:0] inflight_pc;

  logic                    skid_full;
  instruction_s            skid_instr;
  logic [addr_width_p-1:0] skid_pc;
  logic                    skid_load;
  logic                    skid_clear;

  logic                    running;
  logic                    live;
  logic                    stall;

  assign running = (state == RUN);

  // Something is presentable: the skid entry, or data for last cycle's issue.
  assign live = running && (skid_full || inflight_valid);

  // A redirect squashes whatever is on the output in the same cycle.
  assign valid_o = live && !redirect_i;
  assign stall   = valid_o && !ready_i;

  // In-flight data has nowhere to go but the skid when decode stalls; the
  // issue that would follow it is held back, so one entry always suffices.
  assign skid_load  = running && !skid_full && inflight_valid && !ready_i;
  assign skid_clear = !running || halt_i || redirect_i || (skid_full && ready_i);

  fetch_skid_buf #(
    .addr_width_p (addr_width_p)
  ) u_skid (
    .clk           (clk),
    .reset_i       (reset_i),
    .clear         (skid_clear),
    .load          (skid_load),
    .capture_instr (imem_instr_i),
    .capture_pc    (inflight_pc),
    .full          (skid_full),
    .instr         (skid_instr),
    .pc            (skid_pc)
  );

  // NOTE: every output is given a default before any branch so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    imem_addr_o  = pc;
    imem_wen_o   = 1'b0;
    imem_instr_o = load_instr_i;
    if (!running) begin
      imem_addr_o = load_addr_i;
      imem_wen_o  = load_we_i && !reset_i;
    end else if (redirect_i) begin
      imem_addr_o = redirect_pc_i;
    end
  end

  always_comb begin
    instr_o = '0;
    pc_o    = '0;
    if (valid_o) begin
      if (skid_full) begin
        instr_o = skid_instr;
        pc_o    = skid_pc;
      end else begin
        instr_o = imem_instr_i;
        pc_o    = inflight_pc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state          <= HALT;
      pc             <= '0;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else begin
      case (state)
        HALT: begin
          inflight_valid <= 1'b0;
          if (start_i && !halt_i) begin
            state <= RUN;
            pc    <= reset_pc;
          end
        end
        RUN: begin
          if (halt_i) begin
            state          <= HALT;
            inflight_valid <= 1'b0;
          end else if (redirect_i) begin
            inflight_valid <= 1'b1;
            inflight_pc    <= redirect_pc_i;
            pc             <= redirect_pc_i + pc_step;
          end else if (!stall) begin
            inflight_valid <= 1'b1;
            inflight_pc    <= pc;
            pc             <= pc + pc_step;
          end else begin
            // Stalled: any returning data went to the skid; nothing issued.
            inflight_valid <= 1'b0;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic xfer;
  assign xfer = valid_o && ready_i;

  always_ff @(posedge clk) begin
    if (reset_i || start_i) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (xfer && (fetch_cnt_o != 32'hFFFF_FFFF)) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (stall && (stall_cnt_o != 32'hFFFF_FFFF)) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
